// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module : sram_responder
// Cycle-accurate SRAM pin-interface responder with programmable latency.
// Rev    : 1.0
// ============================================================================
module sram_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 17,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  input  logic              sram_ub_n,
  input  logic              sram_lb_n,
  input  logic              sram_we_n,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  output logic              busy
);

  localparam int HALF    = DATA_W / 2;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WRITE_LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DRIVE = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                commit;
  logic                wr_req;
  logic                rd_req;
  logic                drive_ub;
  logic                drive_lb;

  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign idx      = addr_q[IDX_W-1:0];
  // we_n dominates: a write request ignores oe_n entirely
  assign wr_req   = !sram_ce_n && !sram_we_n;
  assign rd_req   = !sram_ce_n &&  sram_we_n && !sram_oe_n;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          addr_d  = sram_addr;
          wdata_d = sram_dq;
          ub_n_d  = sram_ub_n;
          lb_n_d  = sram_lb_n;
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end else if (rd_req) begin
          addr_d  = sram_addr;
          ub_n_d  = sram_ub_n;
          lb_n_d  = sram_lb_n;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (sram_ce_n || sram_oe_n || !sram_we_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            rdata_d = in_range ? mem[idx] : '0;
            state_d = RD_DRIVE;
          end
        end
      end
      RD_DRIVE: begin
        if (sram_ce_n || sram_oe_n || !sram_we_n) state_d = IDLE;
      end
      WR_WAIT: begin
        if (sram_ce_n || sram_we_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            commit  = in_range && !rst;
            state_d = WR_DONE;
          end
        end
      end
      WR_DONE: begin
        if (sram_we_n || sram_ce_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (commit) begin
      if (!ub_n_q) mem[idx][DATA_W-1:HALF] <= wdata_q[DATA_W-1:HALF];
      if (!lb_n_q) mem[idx][HALF-1:0]      <= wdata_q[HALF-1:0];
    end
  end

  assign drive_ub = !rst && (state_q == RD_DRIVE) && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_ub_n;
  assign drive_lb = !rst && (state_q == RD_DRIVE) && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_lb_n;

  assign sram_dq[DATA_W-1:HALF] = drive_ub ? rdata_q[DATA_W-1:HALF] : {(DATA_W - HALF){1'bz}};
  assign sram_dq[HALF-1:0]      = drive_lb ? rdata_q[HALF-1:0]      : {HALF{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// Bench for sram_responder: directed scenarios plus randomized traffic checked
// against an associative-array memory model; undriven bus reads as all ones.
module tb_sram_responder;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 17;
  localparam int DEPTH     = 1024;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;
  localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;
  localparam logic [31:0] DMASK = 32'hFFFE_FFFE;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              ub_n, lb_n, we_n, ce_n, oe_n;
  logic [DATA_W-1:0] tb_dq;
  logic              tb_dq_en;
  logic              busy;
  wire  [DATA_W-1:0] dq;

  assign dq = tb_dq_en ? tb_dq : {DATA_W{1'bz}};
  pullup (dq);

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  sram_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_dq(dq),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_we_n(we_n),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .busy(busy)
  );

  function automatic logic [31:0] model_read(input int a);
    if (a >= DEPTH || !model_mem.exists(a)) return 32'h0;
    return model_mem[a];
  endfunction

  // A write lands only if the request stays asserted across the accept edge plus WRITE_LAT edges
  function automatic void model_write(input int a, input logic [31:0] d, input logic u,
                                      input logic l, input int hold);
    logic [31:0] w;
    if (hold < WRITE_LAT + 1 || a >= DEPTH) return;
    w = model_mem.exists(a) ? model_mem[a] : 32'h0;
    if (!u) w[31:16] = d[31:16];
    if (!l) w[15:0]  = d[15:0];
    model_mem[a] = w;
  endfunction

  task automatic do_write(input int a, input logic [31:0] d, input logic u, input logic l,
                          input int hold, input logic oe_v);
    addr = ADDR_W'(a); tb_dq = d; tb_dq_en = 1'b1; ub_n = u; lb_n = l;
    ce_n = 1'b0; we_n = 1'b0; oe_n = oe_v;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        tb_dq_en = 1'b0;
        addr = ADDR_W'($urandom_range(0, 63));
        ub_n = 1'($urandom_range(0, 1));
        lb_n = 1'($urandom_range(0, 1));
      end
      if (k == hold) begin
        we_n = 1'b1;
        ce_n = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL wr_busy a=%0d k=%0d: got %b expected 1", a, k, busy);
      end
      n_checks++;
      if (dq !== ZBUS) begin
        n_fail++; $display("FAIL wr_bus_z a=%0d k=%0d: got %h expected %h", a, k, dq, ZBUS);
      end
    end
    @(posedge clk); #1;
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_idle a=%0d: got %b expected 0", a, busy);
    end
    model_write(a, d, u, l, hold);
  endtask

  task automatic do_read(input int a, input logic u, input logic l, input int hold, input int rel);
    logic [31:0] w, exp;
    w = model_read(a);
    addr = ADDR_W'(a); ub_n = u; lb_n = l; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == 1) addr = ADDR_W'($urandom_range(0, 63));
      @(negedge clk);
      exp = ZBUS;
      if (k > READ_LAT) begin
        if (!u) exp[31:16] = w[31:16];
        if (!l) exp[15:0]  = w[15:0];
      end
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL rd_bus a=%0d k=%0d: got %h expected %h", a, k, dq, exp);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL rd_busy a=%0d k=%0d: got %b expected 1", a, k, busy);
      end
    end
    case (rel)
      0:       ce_n = 1'b1;
      1:       oe_n = 1'b1;
      default: we_n = 1'b0;
    endcase
    #1;
    n_checks++;
    if (dq !== ZBUS) begin
      n_fail++; $display("FAIL rd_release a=%0d rel=%0d: got %h expected %h", a, rel, dq, ZBUS);
    end
    @(posedge clk); #1;
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rd_idle a=%0d: got %b expected 0", a, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = '0; tb_dq = '0; tb_dq_en = 1'b0;
    ub_n = 1'b1; lb_n = 1'b1; we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (dq !== ZBUS) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", dq, ZBUS); end
    ce_n = 1'b0; oe_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
    ce_n = 1'b1; oe_n = 1'b1; rst = 1'b0;
  endtask

  task automatic test_word_rw();
    do_write(5, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 1'b1);
    do_read(5, 1'b0, 1'b0, 4, 0);
  endtask

  task automatic test_byte_lanes();
    do_write(9, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, 1'b1);
    do_write(9, 32'h1234_5678, 1'b0, 1'b1, 3, 1'b1);
    do_read(9, 1'b0, 1'b0, 4, 0);
    do_read(5, 1'b0, 1'b1, 4, 1);
    do_read(5, 1'b1, 1'b0, 4, 2);
  endtask

  task automatic test_write_abort();
    do_write(5, 32'h0BAD_0BAD, 1'b0, 1'b0, 1, 1'b1);
    do_write(5, 32'h0BAD_0BAD, 1'b0, 1'b0, WRITE_LAT, 1'b1);
    do_read(5, 1'b0, 1'b0, 4, 0);
  endtask

  task automatic test_read_abort();
    do_read(9, 1'b0, 1'b0, 1, 1);
    do_read(9, 1'b0, 1'b0, READ_LAT, 1);
    do_read(5, 1'b0, 1'b0, READ_LAT + 2, 1);
  endtask

  task automatic test_reset_mid();
    addr = ADDR_W'(5); tb_dq = 32'h5A5A_A5A4; tb_dq_en = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    @(posedge clk); #1;
    tb_dq_en = 1'b0; rst = 1'b1;
    repeat (WRITE_LAT + 1) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy: got %b expected 0", busy); end
      n_checks++;
      if (dq !== ZBUS) begin n_fail++; $display("FAIL rstw_bus: got %h expected %h", dq, ZBUS); end
    end
    #1; rst = 1'b0; ce_n = 1'b1; we_n = 1'b1;
    @(negedge clk);
    do_read(5, 1'b0, 1'b0, 4, 0);
    do_read(9, 1'b0, 1'b0, 4, 0);
    // Reset while the bus is being driven
    addr = ADDR_W'(9); ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    repeat (READ_LAT + 1) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dq !== model_read(9)) begin
      n_fail++; $display("FAIL rstr_pre: got %h expected %h", dq, model_read(9));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dq !== ZBUS) begin n_fail++; $display("FAIL rstr_bus: got %h expected %h", dq, ZBUS); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstr_busy: got %b expected 0", busy); end
    ce_n = 1'b1; oe_n = 1'b1; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    do_write(DEPTH + 3, 32'hCAFE_F00D, 1'b0, 1'b0, 4, 1'b1);
    do_read(DEPTH + 3, 1'b0, 1'b0, 4, 0);
    do_write(12, 32'h0F0E_0D0C, 1'b0, 1'b0, 4, 1'b0);
    do_read(12, 1'b0, 1'b0, 4, 0);
  endtask

  task automatic test_random();
    int a, x;
    for (int i = 16; i < 24; i++)
      do_write(i, $urandom & DMASK, 1'b0, 1'b0, WRITE_LAT + 1 + $urandom_range(0, 2), 1'b1);
    for (int n = 0; n < 60; n++) begin
      x = $urandom_range(0, 9);
      a = (x < 8) ? 16 + x : DEPTH + 16 + (x - 8);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom & DMASK, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 5), 1'($urandom_range(0, 1)));
      else
        do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 5), $urandom_range(0, 2));
    end
    for (int i = 16; i < 24; i++) do_read(i, 1'b0, 1'b0, READ_LAT + 1, 0);
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_write_abort();
    test_read_abort();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
